// File: rtl/calc_sequencer.sv
// Operand entry / ALU handshake sequencer: loads two 32-bit operands a byte per button press,
// launches the ALU, waits for its result with a timeout, then lets the operator page through it.
module calc_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enter,
  input  logic [7:0]  inputdata,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [31:0] dataR,
  output logic        alu_start,
  output logic        inputdata_ready,
  output logic [1:0]  byte_sel,
  output logic [7:0]  disp_byte,
  output logic [2:0]  state,
  output logic        timeout_err
);

  // state   | meaning
  // S_LOADA | collecting operand A bytes
  // S_LOADB | collecting operand B bytes
  // S_START | issuing the ALU start pulse
  // S_WAIT  | waiting for alu_done, bounded by TIMEOUT
  // S_SHOW  | paging through the captured result
  // S_ERR   | ALU never answered; wait for the operator
  typedef enum logic [2:0] {
    S_LOADA = 3'b000,
    S_LOADB = 3'b001,
    S_START = 3'b010,
    S_WAIT  = 3'b011,
    S_SHOW  = 3'b100,
    S_ERR   = 3'b101
  } state_t;

  // Width never below 1 so TIMEOUT=0 still elaborates; the counter saturates at TIMEOUT.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  state_t        cur_state;
  logic          enter_q;
  logic          enter_pulse;
  logic [CW-1:0] wait_cnt;

  assign enter_pulse = enter & ~enter_q;
  assign state       = cur_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state       <= S_LOADA;
      enter_q         <= 1'b0;
      byte_sel        <= 2'd0;
      dataA           <= '0;
      dataB           <= '0;
      dataR           <= '0;
      wait_cnt        <= '0;
      alu_start       <= 1'b0;
      inputdata_ready <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      enter_q         <= enter;
      alu_start       <= 1'b0;
      inputdata_ready <= 1'b0;
      case (cur_state)
        S_LOADA: begin
          if (enter_pulse) begin
            dataA[{byte_sel, 3'b000} +: 8] <= inputdata;
            byte_sel <= byte_sel + 2'd1;
            if (byte_sel == 2'd3) cur_state <= S_LOADB;
          end
        end
        S_LOADB: begin
          if (enter_pulse) begin
            dataB[{byte_sel, 3'b000} +: 8] <= inputdata;
            byte_sel <= byte_sel + 2'd1;
            if (byte_sel == 2'd3) begin
              inputdata_ready <= 1'b1;
              cur_state       <= S_START;
            end
          end
        end
        S_START: begin
          alu_start <= 1'b1;
          wait_cnt  <= '0;
          cur_state <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the terminal count still counts as a success.
          if (alu_done) begin
            dataR     <= alu_result;
            byte_sel  <= 2'd0;
            cur_state <= S_SHOW;
          end else if (wait_cnt == TMAX) begin
            dataR       <= '0;
            timeout_err <= 1'b1;
            cur_state   <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (enter_pulse) begin
            byte_sel <= byte_sel + 2'd1;
            if (byte_sel == 2'd3) cur_state <= S_LOADA;
          end
        end
        S_ERR: begin
          if (enter_pulse) begin
            timeout_err <= 1'b0;
            byte_sel    <= 2'd0;
            cur_state   <= S_LOADA;
          end
        end
        default: begin
          timeout_err <= 1'b0;
          byte_sel    <= 2'd0;
          cur_state   <= S_LOADA;
        end
      endcase
    end
  end

  always_comb begin
    disp_byte = 8'h00;
    case (cur_state)
      S_LOADA: disp_byte = dataA[{byte_sel, 3'b000} +: 8];
      S_LOADB: disp_byte = dataB[{byte_sel, 3'b000} +: 8];
      S_SHOW:  disp_byte = dataR[{byte_sel, 3'b000} +: 8];
      default: disp_byte = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer (TIMEOUT=8): operand load, result paging, timeout,
// done-on-terminal-count, held button and asynchronous reset mid-operation.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        enter;
  logic [7:0]  inputdata;
  logic        alu_done;
  logic [31:0] alu_result;
  logic [31:0] dataA, dataB, dataR;
  logic        alu_start, inputdata_ready, timeout_err;
  logic [1:0]  byte_sel;
  logic [7:0]  disp_byte;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] S_LOADA = 3'b000, S_LOADB = 3'b001, S_START = 3'b010,
                         S_WAIT = 3'b011, S_SHOW = 3'b100, S_ERR = 3'b101;

  calc_sequencer #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .enter(enter), .inputdata(inputdata),
    .alu_done(alu_done), .alu_result(alu_result),
    .dataA(dataA), .dataB(dataB), .dataR(dataR),
    .alu_start(alu_start), .inputdata_ready(inputdata_ready),
    .byte_sel(byte_sel), .disp_byte(disp_byte), .state(state),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] b);
    inputdata = b;
    enter = 1'b1;
    step();
    enter = 1'b0;
    step();
  endtask

  // Loads A=0x44332211 and B=0x88776655; returns just after the edge where alu_start rises.
  task automatic load_ops();
    press(8'h11); press(8'h22); press(8'h33); press(8'h44);
    press(8'h55); press(8'h66); press(8'h77);
    inputdata = 8'h88;
    enter = 1'b1;
    step();
    enter = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; enter = 1'b0; inputdata = 8'h00; alu_done = 1'b0; alu_result = '0;
    #2;
    checks++;
    if ({state, byte_sel, alu_start, inputdata_ready, timeout_err, disp_byte} !== 16'h0 ||
        {dataA, dataB, dataR} !== 96'h0) begin
      errors++;
      $display("FAIL reset_state: state=%0d byte_sel=%0d A=%h B=%h R=%h flags=%b%b%b, want all zero",
               state, byte_sel, dataA, dataB, dataR, alu_start, inputdata_ready, timeout_err);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_load();
    press(8'h11); press(8'h22);
    checks++;
    if (dataA !== 32'h0000_2211 || byte_sel !== 2'd2 || disp_byte !== 8'h00) begin
      errors++;
      $display("FAIL load_partial: A=%h sel=%0d disp=%h want 00002211 2 00", dataA, byte_sel, disp_byte);
    end
    press(8'h33); press(8'h44);
    checks++;
    if (dataA !== 32'h4433_2211 || state !== S_LOADB || byte_sel !== 2'd0) begin
      errors++;
      $display("FAIL load_a_done: A=%h state=%0d sel=%0d want 44332211 1 0", dataA, state, byte_sel);
    end
    press(8'h55); press(8'h66); press(8'h77);
    checks++;
    if (disp_byte !== 8'h00 || dataB !== 32'h0077_6655) begin
      errors++;
      $display("FAIL load_b_partial: disp=%h B=%h want 00 00776655", disp_byte, dataB);
    end
    inputdata = 8'h88;
    enter = 1'b1;
    step();
    enter = 1'b0;
    checks++;
    if (state !== S_START || inputdata_ready !== 1'b1 || alu_start !== 1'b0 || dataB !== 32'h8877_6655) begin
      errors++;
      $display("FAIL ready_pulse: state=%0d ready=%b start=%b B=%h want 2 1 0 88776655",
               state, inputdata_ready, alu_start, dataB);
    end
    step();
    checks++;
    if (state !== S_WAIT || inputdata_ready !== 1'b0 || alu_start !== 1'b1) begin
      errors++;
      $display("FAIL start_pulse: state=%0d ready=%b start=%b want 3 0 1", state, inputdata_ready, alu_start);
    end
  endtask

  task automatic test_result();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    enter = 1'b1;
    step();
    enter = 1'b0;
    checks++;
    if (alu_start !== 1'b0 || state !== S_WAIT || byte_sel !== 2'd0) begin
      errors++;
      $display("FAIL wait_ignores_enter: start=%b state=%0d sel=%0d want 0 3 0", alu_start, state, byte_sel);
    end
    step(); step(); step();
    alu_done = 1'b1;
    alu_result = 32'hDEAD_BEEF;
    step();
    alu_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== S_SHOW || disp_byte !== exp_b[i] || byte_sel !== 2'(i)) begin
        errors++;
        $display("FAIL show_byte%0d: state=%0d disp=%h sel=%0d want 4 %h %0d", i, state, disp_byte, byte_sel, exp_b[i], i);
      end
      press(8'hFF);
    end
    checks++;
    if (state !== S_LOADA || byte_sel !== 2'd0 || dataR !== 32'hDEAD_BEEF ||
        dataA !== 32'h4433_2211 || dataB !== 32'h8877_6655 || disp_byte !== 8'h11) begin
      errors++;
      $display("FAIL show_exit: state=%0d sel=%0d R=%h A=%h B=%h disp=%h", state, byte_sel, dataR, dataA, dataB, disp_byte);
    end
    alu_done = 1'b1;
    alu_result = 32'h1111_1111;
    step();
    alu_done = 1'b0;
    checks++;
    if (dataR !== 32'hDEAD_BEEF || state !== S_LOADA) begin
      errors++;
      $display("FAIL done_ignored_loada: R=%h state=%0d want deadbeef 0", dataR, state);
    end
  endtask

  task automatic test_timeout();
    load_ops();
    for (int i = 1; i <= 8; i++) begin
      enter = (i == 3);
      step();
      checks++;
      if (state !== S_WAIT || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait%0d: state=%0d err=%b want 3 0", i, state, timeout_err);
      end
    end
    enter = 1'b0;
    step();
    checks++;
    if (state !== S_ERR || timeout_err !== 1'b1 || dataR !== 32'h0 || disp_byte !== 8'h00) begin
      errors++;
      $display("FAIL timeout_err: state=%0d err=%b R=%h disp=%h want 5 1 0 00", state, timeout_err, dataR, disp_byte);
    end
    press(8'h00);
    checks++;
    if (state !== S_LOADA || timeout_err !== 1'b0 || byte_sel !== 2'd0) begin
      errors++;
      $display("FAIL err_exit: state=%0d err=%b sel=%0d want 0 0 0", state, timeout_err, byte_sel);
    end
  endtask

  task automatic test_done_on_timeout();
    load_ops();
    for (int i = 1; i <= 8; i++) step();
    alu_done = 1'b1;
    alu_result = 32'h1234_5678;
    step();
    alu_done = 1'b0;
    checks++;
    if (state !== S_SHOW || dataR !== 32'h1234_5678 || timeout_err !== 1'b0 || disp_byte !== 8'h78) begin
      errors++;
      $display("FAIL done_at_timeout: state=%0d R=%h err=%b disp=%h want 4 12345678 0 78", state, dataR, timeout_err, disp_byte);
    end
    for (int i = 0; i < 4; i++) press(8'h00);
  endtask

  task automatic test_held_enter();
    inputdata = 8'hA5;
    enter = 1'b1;
    step();
    inputdata = 8'h5A;
    for (int i = 1; i < 20; i++) step();
    enter = 1'b0;
    step();
    checks++;
    if (byte_sel !== 2'd1 || dataA !== 32'h4433_22A5 || state !== S_LOADA) begin
      errors++;
      $display("FAIL held_enter: sel=%0d A=%h state=%0d want 1 443322a5 0", byte_sel, dataA, state);
    end
  endtask

  task automatic test_reset_mid();
    press(8'h01); press(8'h02); press(8'h03);
    press(8'hC1); press(8'hC2);
    checks++;
    if (state !== S_LOADB || byte_sel !== 2'd2 || dataA !== 32'h0302_01A5) begin
      errors++;
      $display("FAIL pre_reset: state=%0d sel=%0d A=%h want 1 2 030201a5", state, byte_sel, dataA);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({state, byte_sel, alu_start, inputdata_ready, timeout_err, disp_byte} !== 16'h0 ||
        {dataA, dataB, dataR} !== 96'h0) begin
      errors++;
      $display("FAIL async_reset: state=%0d sel=%0d A=%h B=%h R=%h want all zero", state, byte_sel, dataA, dataB, dataR);
    end
    step();
    reset = 1'b1;
    alu_done = 1'b1;
    alu_result = 32'hCAFE_F00D;
    step();
    alu_done = 1'b0;
    checks++;
    if (state !== S_LOADA || dataR !== 32'h0 || byte_sel !== 2'd0) begin
      errors++;
      $display("FAIL done_after_reset: state=%0d R=%h sel=%0d want 0 0 0", state, dataR, byte_sel);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_result();
    test_timeout();
    test_done_on_timeout();
    test_held_enter();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
Parameters:
REQ-001 The block SHALL have parameter TIMEOUT, default 255: maximum number of cycles to wait for alu_done after alu_start.
Ports:
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port enter, input, 1: operator button level, synchronous to clk.
REQ-005 The block SHALL have port inputdata, input, 8: operand byte from the switches.
REQ-006 The block SHALL have port alu_done, input, 1: ALU result valid, one-cycle pulse.
REQ-007 The block SHALL have port alu_result, input, 32: ALU result, sampled when alu_done=1.
REQ-008 The block SHALL have ports dataA and dataB, output, 32 each: assembled operands.
REQ-009 The block SHALL have port dataR, output, 32: captured result.
REQ-010 The block SHALL have port alu_start, output, 1: one-cycle start pulse to the ALU.
REQ-011 The block SHALL have port inputdata_ready, output, 1: one-cycle pulse when both operands are complete.
REQ-012 The block SHALL have port byte_sel, output, 2: current byte index.
REQ-013 The block SHALL have port disp_byte, output, 8: byte of the active register for display.
REQ-014 The block SHALL have port state, output, 3: FSM state code.
REQ-015 The block SHALL have port timeout_err, output, 1: high while in S_ERR.

Function
REQ-016 enter SHALL be registered; enterpulse = enter AND NOT enter_q, so a held button yields exactly one pulse, with one cycle of latency after the rising edge.
REQ-017 The FSM SHALL have states S_LOADA=000, S_LOADB=001, S_START=010, S_WAIT=011, S_SHOW=100, S_ERR=101; codes 110/111 SHALL go to S_LOADA on the next cycle.
REQ-018 In S_LOADA, each enterpulse SHALL write inputdata to dataA[byte_sel*8 +: 8] and increment byte_sel.
REQ-019 On the enterpulse with byte_sel=3 in S_LOADA, the FSM SHALL go to S_LOADB with byte_sel=0.
REQ-020 S_LOADB SHALL behave the same as S_LOADA for dataB.
REQ-021 On the 4th byte in S_LOADB, the FSM SHALL pulse inputdata_ready for one cycle, coincident with entering S_START.
REQ-022 In S_START, alu_start SHALL be 1 for exactly one cycle; the wait counter SHALL clear to 0; the FSM SHALL then go to S_WAIT.
REQ-023 In S_WAIT, the counter SHALL increment each cycle.
REQ-024 In S_WAIT, if alu_done=1, dataR SHALL take alu_result, byte_sel SHALL clear to 0, and the FSM SHALL go to S_SHOW.
REQ-025 In S_WAIT, if the counter equals TIMEOUT and alu_done=0, dataR SHALL clear to 0 and the FSM SHALL go to S_ERR.
REQ-026 If alu_done and the timeout occur in the same cycle, alu_done SHALL win.
REQ-027 alu_done outside S_WAIT SHALL be ignored.
REQ-028 In S_SHOW, each enterpulse SHALL increment byte_sel.
REQ-029 On the enterpulse with byte_sel=3 in S_SHOW, the FSM SHALL go to S_LOADA with byte_sel=0; dataA, dataB and dataR SHALL be retained.
REQ-030 In S_ERR, timeout_err SHALL be 1; an enterpulse SHALL go to S_LOADA with byte_sel=0.
REQ-031 enterpulse in S_START or S_WAIT SHALL be ignored.
REQ-032 disp_byte (combinational) SHALL be dataA[byte_sel] in S_LOADA, dataB[byte_sel] in S_LOADB, dataR[byte_sel] in S_SHOW, and 0x00 otherwise.
REQ-033 Only the addressed byte SHALL change on a load; the other bytes SHALL hold their values.
REQ-034 The wait counter SHALL be at least clog2(TIMEOUT+1) bits wide and SHALL NOT wrap before reaching TIMEOUT.

Reset
REQ-035 reset=0 SHALL immediately clear state to S_LOADA and set byte_sel, dataA, dataB, dataR, the counter and enter_q to 0.
REQ-036 reset=0 SHALL immediately set alu_start, inputdata_ready and timeout_err to 0.
REQ-037 Reset asserted mid-operation, including in S_WAIT, SHALL abort; a later alu_done SHALL be ignored until S_WAIT is re-entered.
REQ-038 Reset deassertion SHALL be synchronous in effect: the first state change occurs on the first rising clk edge after reset=1.

Verification
REQ-039 Scenario: 8 enter presses with bytes 11,22,33,44,55,66,77,88 -> dataA=0x44332211, dataB=0x88776655, one inputdata_ready pulse, alu_start 1 cycle later.
REQ-040 Scenario: alu_done with alu_result=0xDEADBEEF 5 cycles after alu_start -> state=S_SHOW, disp_byte=0xEF; 3 presses -> 0xBE, 0xAD, 0xDE; 4th press -> S_LOADA, byte_sel=0.
REQ-041 Scenario: TIMEOUT=8 and no alu_done -> S_ERR exactly 9 cycles after the start pulse, timeout_err=1, dataR=0; enter -> S_LOADA.
REQ-042 Scenario: alu_done on the timeout cycle -> S_SHOW, dataR captured, timeout_err stays 0.
REQ-043 Scenario: enter held high 20 cycles in S_LOADA -> exactly one byte written, byte_sel=1.
REQ-044 Scenario: reset pulsed low after 2 bytes of B -> all outputs 0, state=S_LOADA, async (no clk edge needed).
